wb_arith_unit: RTL and testbench
================================

// Module: wb_arith_unit
// PURPOSE
//  Parametrised Wishbone-slave arithmetic peripheral in the user project area.
//  Firmware writes operands and an opcode, starts an operation, then polls STATUS and reads RESULT.
//  Supports WIDTH-bit add/sub/logic ops and an iterative shift-add multiply.
//  The low result bits also drive user GPIO pads (output only).
// PARAMETERS
//  BASE_ADDRESS  32'h3000_0000  Wishbone window base; window is BASE_ADDRESS[31:8], 256 B
//  WIDTH         8              operand width, 2..32
//  OUT_BITS      16             result bits driven to pads, 1..2*WIDTH
// PORTS
//  clk        in   1         single system clock
//  reset      in   1         synchronous reset, active-low (asserted when 0, sampled on posedge clk)
//  wbs_stb_i  in   1         Wishbone strobe
//  wbs_cyc_i  in   1         Wishbone cycle
//  wbs_we_i   in   1         1=write, 0=read
//  wbs_sel_i  in   4         byte enables, honoured on writes
//  wbs_dat_i  in   32        write data
//  wbs_adr_i  in   32        byte address
//  wbs_ack_o  out  1         one-cycle acknowledge
//  wbs_dat_o  out  32        read data; unused upper bits 0
//  result     out  OUT_BITS  RESULT[OUT_BITS-1:0], registered
//  io_oeb     out  OUT_BITS  constant 0 (pads are outputs)
// BEHAVIOUR
//  Register map (offset: field):
//   0x00 CTRL: [0] START (write-1, reads 0); [3:1] OP: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6-7 illegal
//   0x04 OPA[WIDTH-1:0]    0x08 OPB[WIDTH-1:0]
//   0x0C RES_LO = RESULT[31:0]    0x10 RES_HI = RESULT[2*WIDTH-1:32], 0 if WIDTH<=16
//   0x14 STATUS: [0] BUSY, [1] DONE, [2] CARRY, [3] ZERO, [4] ERR; write 1 to [4] clears ERR
//  Bus handshake:
//   - Hit = cyc & stb & adr[31:8]==BASE[31:8] & !ack.
//   - Hit -> ack=1 on the next edge for exactly one cycle; ack drops the following cycle; no back-to-back acks.
//   - Unmapped offsets inside the window: ack, read 0, write ignored.
//   - Addresses outside the window: never acked.
//   - Read data is registered with ack.
//  Reset (reset==0): ack=0, dat_o=0, all registers 0, result=0, FSM=IDLE. This applies mid-operation too: any MUL is abandoned.
//  FSM IDLE -> RUN -> IDLE:
//   - START write with legal OP in IDLE: DONE<=0.
//   - ADD/SUB/logic ops: RESULT and flags written one cycle after the accepting edge; DONE=1; stays IDLE.
//   - MUL: BUSY=1; RUN for exactly WIDTH cycles of shift-add; then RESULT written, DONE=1, BUSY=0.
//  Arithmetic and flags:
//   - ADD: RESULT = zero-extended WIDTH+1-bit sum; CARRY = bit WIDTH.
//   - SUB: RESULT = OPA-OPB mod 2^WIDTH; CARRY = borrow (OPA<OPB).
//   - Logic ops: CARRY=0.
//   - MUL: 2*WIDTH-bit unsigned product; CARRY=0.
//   - ZERO = (RESULT==0).
//  Error and boundary cases:
//   - START with illegal OP: no operation; ERR=1 (sticky).
//   - Any write to CTRL/OPA/OPB while BUSY: acked but ignored; ERR=1. Reads are always served.
//   - A read of RES_LO clears DONE.
//   - A START on the same edge as a RES_LO read: DONE is cleared, then set by the op normally.
//   - Operand writes honour wbs_sel_i; bits at and above WIDTH are dropped.
//  Pads: result updates whenever RESULT is written.
// CONFIGURATION
//  ARITH_IRQ_EN defined:
//   - Adds output port irq (1 bit, after io_oeb) and CTRL[4] IRQ_ENA (R/W, reset 0).
//   - irq = IRQ_ENA & (DONE | ERR), registered.
//  ARITH_IRQ_EN undefined: no irq port; CTRL[4] reads 0 and ignores writes.
// TESTING
//  1 Hold reset=0 for 3 cycles, release -> ack=0, STATUS=0, result=0, all registers read 0.
//  2 WIDTH=8: OPA=0xF0, OPB=0x20, CTRL=0x01 (ADD) -> RES_LO=0x110, CARRY=1, DONE=1, result=0x0110.
//  3 OPA=0x05, OPB=0x07, SUB -> RES_LO=0xFE, CARRY=1. OPA=OPB=0x33, XOR -> RES_LO=0, ZERO=1.
//  4 OPA=0xFF, OPB=0xFF, MUL -> BUSY=1 for 8 cycles, then RES_LO=0xFE01, DONE=1. Writing OPA mid-run -> ERR=1, product unchanged.
//  5 CTRL=0x0D (OP 6) -> ERR=1, DONE unchanged. Write STATUS=0x10 -> ERR=0. Read offset 0x40 -> ack, data 0. Read BASE+0x100 -> no ack.
//  6 Start MUL, drive reset=0 at cycle 3 of RUN -> next cycle BUSY=0, RES_LO=0. Repeat a read with stb held -> ack pulses alternate 1,0.

Source files
------------

// File: rtl/wb_arith_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_arith_unit                                                |
// | Description : Wishbone-slave arithmetic peripheral. Firmware loads OPA and |
// |               OPB, writes CTRL with START and an opcode, polls STATUS and  |
// |               reads RESULT. ADD/SUB/AND/OR/XOR complete one cycle after   |
// |               the START is accepted. MUL is an iterative shift-add that    |
// |               takes WIDTH cycles. The low OUT_BITS result bits drive pads. |
// | Optional    : define ARITH_IRQ_EN to add the irq output and CTRL[4]        |
// |               IRQ_ENA; irq = IRQ_ENA & (DONE | ERR), registered.           |
// | Ports       : clk, reset (sync, active-low)                                |
// |               wbs_*  Wishbone slave: stb, cyc, we, sel, dat_i, adr, ack,   |
// |                      dat_o                                                 |
// |               result  RESULT[OUT_BITS-1:0] to the pads, registered         |
// |               io_oeb  constant 0, the pads are outputs only                |
// |               irq     interrupt request (ARITH_IRQ_EN builds only)         |
// | Map         : 0x00 CTRL  0x04 OPA  0x08 OPB  0x0C RES_LO  0x10 RES_HI      |
// |               0x14 STATUS {ERR, ZERO, CARRY, DONE, BUSY}                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module wb_arith_unit #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          WIDTH        = 8,
    parameter int          OUT_BITS     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [OUT_BITS-1:0] result,
    output logic [OUT_BITS-1:0] io_oeb
`ifdef ARITH_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam int c_cnt_w = $clog2(WIDTH);

    typedef logic [2*WIDTH-1:0] res_t;
    typedef logic [c_cnt_w-1:0] cnt_t;
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam cnt_t c_cnt_last = cnt_t'(WIDTH - 1);

    localparam logic [5:0] c_reg_ctrl   = 6'd0;
    localparam logic [5:0] c_reg_opa    = 6'd1;
    localparam logic [5:0] c_reg_opb    = 6'd2;
    localparam logic [5:0] c_reg_res_lo = 6'd3;
    localparam logic [5:0] c_reg_res_hi = 6'd4;
    localparam logic [5:0] c_reg_status = 6'd5;

    localparam logic [2:0] c_op_add = 3'd0;
    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_and = 3'd2;
    localparam logic [2:0] c_op_or  = 3'd3;
    localparam logic [2:0] c_op_xor = 3'd4;
    localparam logic [2:0] c_op_mul = 3'd5;

    // Registers
    state_t             r_state;
    logic               r_ack;
    logic [31:0]        r_dat_o;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    res_t               r_result;
    logic               r_done;
    logic               r_carry;
    logic               r_zero;
    logic               r_err;
    logic               r_alu_pend;
    res_t               r_acc;
    res_t               r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    cnt_t               r_cnt;
`ifdef ARITH_IRQ_EN
    logic               r_irq_ena;
    logic               r_irq;
`endif

    // Combinational signals
    state_t             w_state_nxt;
    logic               w_busy;
    logic               w_hit;
    logic               w_wr;
    logic               w_rd;
    logic [5:0]         w_word;
    logic               w_wr_guarded;
    logic               w_blocked;
    logic               w_start;
    logic               w_legal;
    logic               w_start_mul;
    logic               w_start_alu;
    logic               w_illegal;
    logic               w_err_clr;
    logic               w_mul_last;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    res_t               w_alu_res;
    logic               w_alu_carry;
    res_t               w_acc_step;
    logic [63:0]        w_res_ext;
    logic [31:0]        w_opa_wr;
    logic [31:0]        w_opb_wr;
    logic [31:0]        w_rdata;
    logic               w_irq_ena_rd;
    logic               w_unused_bits;

    assign w_busy = (r_state == S_RUN);

    // Bus decode. The !ack term forces an idle cycle between accesses, so
    // a held strobe produces alternating acknowledges.
    assign w_hit  = wbs_cyc_i & wbs_stb_i & ~r_ack &
                    (wbs_adr_i[31:8] == BASE_ADDRESS[31:8]);
    assign w_wr   = w_hit & wbs_we_i;
    assign w_rd   = w_hit & ~wbs_we_i;
    assign w_word = wbs_adr_i[7:2];

    assign w_wr_guarded = w_wr & ((w_word == c_reg_ctrl) |
                                  (w_word == c_reg_opa)  |
                                  (w_word == c_reg_opb));
    assign w_blocked    = w_wr_guarded & w_busy;

    assign w_start     = w_wr & (w_word == c_reg_ctrl) & wbs_sel_i[0] &
                         wbs_dat_i[0] & ~w_busy;
    assign w_legal     = (wbs_dat_i[3:1] <= c_op_mul);
    assign w_start_mul = w_start & w_legal & (wbs_dat_i[3:1] == c_op_mul);
    assign w_start_alu = w_start & w_legal & (wbs_dat_i[3:1] != c_op_mul);
    assign w_illegal   = w_start & ~w_legal;
    assign w_err_clr   = w_wr & (w_word == c_reg_status) & wbs_sel_i[0] &
                         wbs_dat_i[4];

    assign w_mul_last  = (r_state == S_RUN) && (r_cnt == c_cnt_last);

    // Single-cycle operations, evaluated from the opcode latched at START
    assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
    assign w_diff = r_opa - r_opb;

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (r_op)
            c_op_add: begin
                w_alu_res   = res_t'(w_sum);
                w_alu_carry = w_sum[WIDTH];
            end
            c_op_sub: begin
                w_alu_res   = res_t'(w_diff);
                w_alu_carry = (r_opa < r_opb);
            end
            c_op_and: w_alu_res = res_t'(r_opa & r_opb);
            c_op_or:  w_alu_res = res_t'(r_opa | r_opb);
            c_op_xor: w_alu_res = res_t'(r_opa ^ r_opb);
            default:  w_alu_res = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Byte-lane merge for operand writes; lanes beyond WIDTH fall off when
    // the merged word is truncated into the operand register.
    always_comb begin
        w_opa_wr = 32'(r_opa);
        w_opb_wr = 32'(r_opb);
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
                w_opa_wr[8*b +: 8] = wbs_dat_i[8*b +: 8];
                w_opb_wr[8*b +: 8] = wbs_dat_i[8*b +: 8];
            end
        end
    end

`ifdef ARITH_IRQ_EN
    assign w_irq_ena_rd = r_irq_ena;
    assign irq          = r_irq;
`else
    assign w_irq_ena_rd = 1'b0;
`endif

    // RES_HI naturally reads 0 when the product fits in 32 bits
    assign w_res_ext = 64'(r_result);

    always_comb begin
        w_rdata = '0;
        case (w_word)
            c_reg_ctrl:   w_rdata = {27'd0, w_irq_ena_rd, r_op, 1'b0};
            c_reg_opa:    w_rdata = 32'(r_opa);
            c_reg_opb:    w_rdata = 32'(r_opb);
            c_reg_res_lo: w_rdata = w_res_ext[31:0];
            c_reg_res_hi: w_rdata = w_res_ext[63:32];
            c_reg_status: w_rdata = {27'd0, r_err, r_zero, r_carry, r_done, w_busy};
            default:      w_rdata = '0;
        endcase
    end

    assign w_unused_bits = ^{wbs_adr_i[1:0], w_opa_wr, w_opb_wr};

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_mul) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == c_cnt_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus, register file and datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ack      <= 1'b0;
            r_dat_o    <= '0;
            r_op       <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_err      <= 1'b0;
            r_alu_pend <= 1'b0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
`ifdef ARITH_IRQ_EN
            r_irq_ena  <= 1'b0;
            r_irq      <= 1'b0;
`endif
        end else begin
            r_ack   <= w_hit;
            r_dat_o <= w_rd ? w_rdata : '0;

            if (w_wr && !w_busy) begin
                case (w_word)
                    c_reg_ctrl: begin
                        if (wbs_sel_i[0]) begin
                            r_op <= wbs_dat_i[3:1];
`ifdef ARITH_IRQ_EN
                            r_irq_ena <= wbs_dat_i[4];
`endif
                        end
                    end
                    c_reg_opa: r_opa <= w_opa_wr[WIDTH-1:0];
                    c_reg_opb: r_opb <= w_opb_wr[WIDTH-1:0];
                    default: ;
                endcase
            end

            if (w_err_clr) r_err <= 1'b0;
            if (w_blocked || w_illegal) r_err <= 1'b1;

            // A RES_LO read clears DONE; a START in the same cycle also
            // clears it, and completion (later below) sets it again.
            if (w_rd && (w_word == c_reg_res_lo)) r_done <= 1'b0;
            if (w_start_alu || w_start_mul) r_done <= 1'b0;

            r_alu_pend <= w_start_alu;

            if (w_start_mul) begin
                r_acc    <= '0;
                r_mcand  <= res_t'(r_opa);
                r_mplier <= r_opb;
                r_cnt    <= '0;
            end

            if (r_state == S_RUN) begin
                r_acc    <= w_acc_step;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_mul_last) begin
                    r_result <= w_acc_step;
                    r_carry  <= 1'b0;
                    r_zero   <= (w_acc_step == '0);
                    r_done   <= 1'b1;
                end
            end

            if (r_alu_pend) begin
                r_result <= w_alu_res;
                r_carry  <= w_alu_carry;
                r_zero   <= (w_alu_res == '0);
                r_done   <= 1'b1;
            end

`ifdef ARITH_IRQ_EN
            r_irq <= r_irq_ena & (r_done | r_err);
`endif
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat_o;
    assign result    = r_result[OUT_BITS-1:0];
    assign io_oeb    = '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_arith_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_arith_unit                                             |
// | Description : Directed bench for wb_arith_unit (WIDTH=8, OUT_BITS=16).     |
// |               Read expectations go into a scoreboard queue when a read is  |
// |               issued and are compared when the acknowledge arrives.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_wb_arith_unit;

    localparam logic [31:0] c_base     = 32'h3000_0000;
    localparam int          c_width    = 8;
    localparam int          c_out_bits = 16;

    localparam logic [31:0] c_ctrl   = c_base + 32'h00;
    localparam logic [31:0] c_opa    = c_base + 32'h04;
    localparam logic [31:0] c_opb    = c_base + 32'h08;
    localparam logic [31:0] c_res_lo = c_base + 32'h0C;
    localparam logic [31:0] c_res_hi = c_base + 32'h10;
    localparam logic [31:0] c_status = c_base + 32'h14;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  stb;
    logic                  cyc;
    logic                  we;
    logic [3:0]            sel;
    logic [31:0]           dat_i;
    logic [31:0]           adr;
    logic                  ack;
    logic [31:0]           dat_o;
    logic [c_out_bits-1:0] result;
    logic [c_out_bits-1:0] io_oeb;
`ifdef ARITH_IRQ_EN
    logic                  irq;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          cyc_cnt  = 0;
    logic [31:0] sb_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_arith_unit #(
        .BASE_ADDRESS (c_base),
        .WIDTH        (c_width),
        .OUT_BITS     (c_out_bits)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .result    (result),
        .io_oeb    (io_oeb)
`ifdef ARITH_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus access: drive at a negedge, wait (bounded) for ack, release.
    task automatic bus_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic got, output logic [31:0] rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        got = 1'b0;
        rd  = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                rd  = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input string tag);
        logic        got;
        logic [31:0] rd;
        bus_cycle(1'b1, a, d, s, got, rd);
        check({tag, "_ack"}, 32'(got), 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic        got;
        logic [31:0] rd;
        logic [31:0] e;
        string       t;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        bus_cycle(1'b0, a, 32'd0, 4'hF, got, rd);
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        if (got) begin
            check(t, rd, e);
        end else begin
            checks++;
            failures++;
            $error("FAIL %s_timeout observed=no_ack expected=ack", t);
        end
    endtask

    // Independent reference for the single-cycle ops and the multiply
    function automatic logic [31:0] model(input int op, input logic [7:0] a,
                                          input logic [7:0] b, output logic c);
        logic [31:0] r;
        c = 1'b0;
        case (op)
            0: begin r = 32'(a) + 32'(b); c = r[8]; end
            1: begin r = 32'(a) - 32'(b); r = r & 32'hFF; c = (a < b); end
            2: r = 32'(a & b);
            3: r = 32'(a | b);
            4: r = 32'(a ^ b);
            default: r = 32'(a) * 32'(b);
        endcase
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] er;
        logic        c;
        logic        got;
        logic [31:0] rd;
        int          op;
        int          start_cyc;
        int          n;

        reset = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat_o", dat_o, 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_io_oeb", 32'(io_oeb), 32'd0);
        reset = 1'b1;
        wb_read(c_ctrl,   32'd0, "rst_ctrl");
        wb_read(c_opa,    32'd0, "rst_opa");
        wb_read(c_opb,    32'd0, "rst_opb");
        wb_read(c_res_lo, 32'd0, "rst_res_lo");
        wb_read(c_res_hi, 32'd0, "rst_res_hi");
        wb_read(c_status, 32'd0, "rst_status");

        // Operand width truncation and byte enables
        wb_write(c_opa, 32'h1234_5677, 4'hF, "opa_wide");
        wb_read(c_opa, 32'h77, "opa_trunc");
        wb_write(c_opa, 32'h0000_00F0, 4'hF, "opa_f0");
        wb_write(c_opb, 32'h0000_0020, 4'hF, "opb_20");
        wb_write(c_opb, 32'h0000_AB55, 4'b0010, "opb_sel");
        wb_read(c_opb, 32'h20, "opb_sel_kept");

        // ADD with carry out
        wb_write(c_ctrl, 32'h01, 4'hF, "add_start");
        wb_read(c_status, 32'h06, "add_status");
        wb_read(c_res_lo, 32'h110, "add_res_lo");
        check("add_pads", 32'(result), 32'h0110);
        wb_read(c_status, 32'h04, "add_done_cleared");

        // Mixed operations against the reference model
        for (int i = 0; i < 12; i++) begin
            op = i % 6;
            a  = 8'($urandom);
            b  = 8'($urandom);
            er = model(op, a, b, c);
            wb_write(c_opa, 32'(a), 4'hF, "rnd_opa");
            wb_write(c_opb, 32'(b), 4'hF, "rnd_opb");
            wb_write(c_ctrl, 32'((op << 1) | 1), 4'hF, "rnd_start");
            repeat (c_width + 4) @(negedge clk);
            wb_read(c_status, {28'd0, (er == 32'd0), c, 1'b1, 1'b0},
                    $sformatf("rnd_status_op%0d", op));
            wb_read(c_res_lo, er, $sformatf("rnd_res_op%0d_%0h_%0h", op, a, b));
            check($sformatf("rnd_pads_op%0d", op), 32'(result), er & 32'hFFFF);
        end

        // SUB with borrow, XOR giving zero
        wb_write(c_opa, 32'h05, 4'hF, "sub_opa");
        wb_write(c_opb, 32'h07, 4'hF, "sub_opb");
        wb_write(c_ctrl, 32'h03, 4'hF, "sub_start");
        wb_read(c_status, 32'h06, "sub_status");
        wb_read(c_res_lo, 32'hFE, "sub_res_lo");
        wb_write(c_opa, 32'h33, 4'hF, "xor_opa");
        wb_write(c_opb, 32'h33, 4'hF, "xor_opb");
        wb_write(c_ctrl, 32'h09, 4'hF, "xor_start");
        wb_read(c_status, 32'h0A, "xor_status");
        wb_read(c_res_lo, 32'h0, "xor_res_lo");

        // MUL 0xFF * 0xFF: result lands WIDTH cycles after acceptance
        wb_write(c_opa, 32'hFF, 4'hF, "mul_opa");
        wb_write(c_opb, 32'hFF, 4'hF, "mul_opb");
        wb_write(c_ctrl, 32'h0B, 4'hF, "mul_start");
        start_cyc = cyc_cnt;
        n = 0;
        while (result !== 16'hFE01 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("mul_latency", 32'(cyc_cnt - start_cyc), 32'd8);
        wb_read(c_status, 32'h02, "mul_status");
        wb_read(c_res_lo, 32'hFE01, "mul_res_lo");
        wb_read(c_res_hi, 32'h0, "mul_res_hi");

        // MUL with an operand write while busy
        wb_write(c_ctrl, 32'h0B, 4'hF, "mul2_start");
        wb_write(c_opa, 32'h01, 4'hF, "mul2_busy_wr");
        wb_read(c_status, 32'h11, "mul2_busy_err");
        repeat (12) @(negedge clk);
        wb_read(c_status, 32'h12, "mul2_done_err");
        wb_read(c_res_lo, 32'hFE01, "mul2_res_lo");
        wb_read(c_opa, 32'hFF, "mul2_opa_kept");

        // ERR clear, illegal opcode, unmapped offsets
        wb_write(c_status, 32'h10, 4'hF, "err_clr");
        wb_read(c_status, 32'h00, "err_cleared");
        wb_write(c_ctrl, 32'h01, 4'hF, "add2_start");
        wb_read(c_status, 32'h06, "add2_status");
        wb_write(c_ctrl, 32'h0D, 4'hF, "illegal_start");
        wb_read(c_status, 32'h16, "illegal_status");
        check("illegal_pads", 32'(result), 32'h01FE);
        wb_write(c_status, 32'h10, 4'hF, "err_clr2");
        wb_read(c_status, 32'h06, "err_cleared2");
        wb_read(c_base + 32'h40, 32'h0, "unmapped_rd");
        wb_write(c_base + 32'h40, 32'hFFFF_FFFF, 4'hF, "unmapped_wr");
        wb_read(c_opa, 32'hFF, "unmapped_no_effect");
        bus_cycle(1'b0, c_base + 32'h100, 32'd0, 4'hF, got, rd);
        check("outside_no_ack", 32'(got), 32'd0);

        // Reset in the middle of a multiply
        wb_write(c_ctrl, 32'h0B, 4'hF, "mul3_start");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_pads", 32'(result), 32'd0);
        wb_read(c_status, 32'h0, "midrst_status");
        wb_read(c_res_lo, 32'h0, "midrst_res_lo");
        wb_read(c_opa, 32'h0, "midrst_opa");

        // Held strobe: acknowledges alternate
        wb_write(c_opa, 32'h5A, 4'hF, "hold_opa");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = c_opa; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                sb_q.push_back(32'h5A);
                tag_q.push_back($sformatf("hold_dat%0d", i));
            end
            @(negedge clk);
            check($sformatf("hold_ack%0d", i), 32'(ack), 32'((i % 2) == 0));
            if (ack && sb_q.size() > 0) begin
                er = sb_q.pop_front();
                check(tag_q.pop_front(), dat_o, er);
            end
        end
        cyc = 1'b0; stb = 1'b0;
        check("hold_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
